ram_port_arbiter: RTL and testbench

Arbitrates RAM port A of the dual-port video/data RAM between two requesters: requester 0 (ALU/CPU core) and requester 1 (auxiliary master, e.g. loader or blitter). The block performs round-robin arbitration, drives the RAM port from registers, and tracks in-flight reads so that read data returns only to the requester that issued the read. It sits between the masters and the RAM, entirely in the `clock_cpu` domain.

---
 rtl/ram_port_arbiter.sv | 135 +++++++++++++
 tb/tb_ram_port_arbiter.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: round-robin arbiter for RAM port A shared by the CPU core
// (requester 0) and an auxiliary master (requester 1). Drives the RAM port
// from registers and routes read data back only to the requester that issued
// the read, using a {valid, owner} tracking pipe matched to the RAM latency.
// Optional feature macro: RAM_PORT_ARBITER_LOCK_EN (ownership lock via lockN).
module ram_port_arbiter #(
  parameter int READ_LAT = 2,
  parameter int AW       = 16,
  parameter int DW       = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  input  logic          lock0,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] ram_address,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  input  logic [DW-1:0] ram_q,
  output logic          busy
);

  // Last accepted requester; 1 after reset so requester 0 wins the first tie.
  logic            r_last;
  logic [AW-1:0]   r_ramAddress;
  logic [DW-1:0]   r_ramData;
  logic            r_ramWren;
  logic [READ_LAT:0] r_pipeValid;
  logic [READ_LAT:0] r_pipeOwner;

  logic w_gnt0;
  logic w_gnt1;
  logic w_hold0;
  logic w_hold1;
  logic w_acc0;
  logic w_acc1;
  logic w_readIssue;

`ifdef RAM_PORT_ARBITER_LOCK_EN
  // A lock only counts for the requester that currently owns the port.
  assign w_hold0 = (r_last == 1'b0) && lock0;
  assign w_hold1 = (r_last == 1'b1) && lock1;
`else
  // Lock inputs exist on the port list but carry no meaning in this build.
  logic w_unusedLock;
  assign w_unusedLock = lock0 | lock1;
  assign w_hold0 = 1'b0;
  assign w_hold1 = 1'b0;
`endif

  // Combinational grant: a held lock wins outright, otherwise round-robin.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (w_hold0) begin
      w_gnt0 = req0;
    end else if (w_hold1) begin
      w_gnt1 = req1;
    end else if (req0 && req1) begin
      w_gnt0 = r_last;
      w_gnt1 = ~r_last;
    end else begin
      w_gnt0 = req0;
      w_gnt1 = req1;
    end
  end

  assign gnt0        = w_gnt0;
  assign gnt1        = w_gnt1;
  assign w_acc0      = req0 & w_gnt0;
  assign w_acc1      = req1 & w_gnt1;
  assign w_readIssue = (w_acc0 & ~we0) | (w_acc1 & ~we1);

  // Round-robin pointer moves only when an access is actually accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_last <= 1'b1;
    end else if (w_acc0) begin
      r_last <= 1'b0;
    end else if (w_acc1) begin
      r_last <= 1'b1;
    end
  end

  // Registered RAM drive; address/data hold when idle, write enable drops.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ramAddress <= '0;
      r_ramData    <= '0;
      r_ramWren    <= 1'b0;
    end else if (w_acc0) begin
      r_ramAddress <= addr0;
      r_ramData    <= wdata0;
      r_ramWren    <= we0;
    end else if (w_acc1) begin
      r_ramAddress <= addr1;
      r_ramData    <= wdata1;
      r_ramWren    <= we1;
    end else begin
      r_ramWren    <= 1'b0;
    end
  end

  // Tracking pipe: the tail lines up with ram_q for the read that entered it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pipeValid <= '0;
      r_pipeOwner <= '0;
    end else begin
      r_pipeValid <= {r_pipeValid[READ_LAT-1:0], w_readIssue};
      r_pipeOwner <= {r_pipeOwner[READ_LAT-1:0], w_acc1};
    end
  end

  assign ram_address = r_ramAddress;
  assign ram_data    = r_ramData;
  assign ram_wren    = r_ramWren;
  assign rvalid0     = r_pipeValid[READ_LAT] & ~r_pipeOwner[READ_LAT];
  assign rvalid1     = r_pipeValid[READ_LAT] &  r_pipeOwner[READ_LAT];
  assign rdata       = ram_q;
  assign busy        = |r_pipeValid;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: randomized and directed bench for ram_port_arbiter with a
// behavioural RAM and a transaction-level reference model (winner selection,
// shadow memory and a queue of pending read returns).
module tb_ram_port_arbiter;

  localparam int READ_LAT = 2;
  localparam int AW = 16;
  localparam int DW = 16;

  logic          clock;
  logic          reset;
  logic          req0, req1, we0, we1, lock0, lock1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_address;

  int nVectors;
  int nMiscompares;

  ram_port_arbiter #(.READ_LAT(READ_LAT), .AW(AW), .DW(DW)) dut (
    .clock(clock), .reset(reset),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .lock0(lock0), .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
    .ram_q(ram_q), .busy(busy)
  );

  // Free-running clock, posedges at 5, 15, 25, ...
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural synchronous RAM: READ_LAT register stages after the address.
  logic          ramInit;
  logic [DW-1:0] ramMem [0:1023];
  logic [DW-1:0] qPipe  [0:READ_LAT-1];

  function automatic logic [DW-1:0] initVal(int a);
    logic [31:0] t;
    if (a == 16) return 16'hBEEF;
    t = (a * 40503) ^ 32'h1357;
    return t[DW-1:0];
  endfunction

  always @(posedge clock) begin
    if (ramInit) begin
      for (int i = 0; i < 1024; i++) ramMem[i] <= initVal(i);
    end else if (ram_wren) begin
      ramMem[ram_address[9:0]] <= ram_data;
    end
    qPipe[0] <= ramMem[ram_address[9:0]];
    for (int i = 1; i < READ_LAT; i++) qPipe[i] <= qPipe[i-1];
  end
  assign ram_q = qPipe[READ_LAT-1];

  // Reference model: who wins, what the RAM port should show, and which reads
  // are owed to whom and on which cycle.
  typedef struct {
    int            owner;
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  rd_t           pend[$];
  logic [DW-1:0] shadow [0:1023];
  int            mLast;
  int            mWinner;
  int            cyc;
  logic          expWren;
  logic [AW-1:0] expAddr;
  logic [DW-1:0] expData;
  logic          eGnt0, eGnt1, eRv0, eRv1, eBusy;
  logic [DW-1:0] eRdata;

  function void model_reset();
    pend.delete();
    mLast   = 1;
    expWren = 1'b0;
    expAddr = '0;
    expData = '0;
  endfunction

  function void compute_expect();
    int lockedTo;
    lockedTo = -1;
`ifdef RAM_PORT_ARBITER_LOCK_EN
    if (mLast == 0 && lock0) lockedTo = 0;
    if (mLast == 1 && lock1) lockedTo = 1;
`endif
    if (lockedTo == 0)      mWinner = req0 ? 0 : -1;
    else if (lockedTo == 1) mWinner = req1 ? 1 : -1;
    else if (req0 && req1)  mWinner = 1 - mLast;
    else if (req0)          mWinner = 0;
    else if (req1)          mWinner = 1;
    else                    mWinner = -1;
    eGnt0  = (mWinner == 0);
    eGnt1  = (mWinner == 1);
    eRv0   = 1'b0;
    eRv1   = 1'b0;
    eRdata = '0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      eRv0   = (pend[0].owner == 0);
      eRv1   = (pend[0].owner == 1);
      eRdata = pend[0].data;
    end
    eBusy = 1'b0;
    foreach (pend[i]) if (pend[i].due - READ_LAT <= cyc) eBusy = 1'b1;
  endfunction

  // Commit the current cycle's accept to the model, then move to the next cycle.
  task advance();
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    if (pend.size() > 0 && pend[0].due == cyc) void'(pend.pop_front());
    if (mWinner >= 0) begin
      w = (mWinner == 0) ? we0 : we1;
      a = (mWinner == 0) ? addr0 : addr1;
      d = (mWinner == 0) ? wdata0 : wdata1;
      mLast   = mWinner;
      expWren = w;
      expAddr = a;
      expData = d;
      if (w) shadow[a[9:0]] = d;
      else   pend.push_back('{mWinner, shadow[a[9:0]], cyc + 1 + READ_LAT});
    end else begin
      expWren = 1'b0;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
             input logic [DW-1:0] d0, input logic l0,
             input logic r1, input logic w1, input logic [AW-1:0] a1,
             input logic [DW-1:0] d1, input logic l1);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0; lock0 = l0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1; lock1 = l1;
  endtask

  task test_reset();
    #1;
    nVectors++;
    if ({rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data, gnt0, gnt1} !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_values got rv=%b%b busy=%b wren=%b addr=%h data=%h gnt=%b%b, expected all zero",
               rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data, gnt0, gnt1);
    end
    repeat (2) @(posedge clock);
    #1;
    ramInit = 1'b0;
    reset   = 1'b0;
    cyc     = 0;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      if (k == 0)      drive(1, 0, 16'h0005, 0, 0, 0, 0, 0, 0, 0);
      else if (k == 1) drive(0, 0, 0, 0, 0, 1, 0, 16'h0006, 0, 0);
      else             drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      compute_expect();
      nVectors++;
      if ({gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data} !==
          {eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData}) begin
        nMiscompares++;
        $display("[TB] FAIL reset_pre cyc=%0d got gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h, expected gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h",
                 cyc, gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data,
                 eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData);
      end
      if (k < 2) advance();
    end
    // Reads are in flight here; reset lands in the middle of the cycle.
    #(-2 + 2);
    reset = 1'b1;
    #1;
    nVectors++;
    if ({rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data} !== '0) begin
      nMiscompares++;
      $display("[TB] FAIL reset_midcycle got rv=%b%b busy=%b wren=%b addr=%h data=%h, expected all zero",
               rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data);
    end
    model_reset();
    @(posedge clock);
    #1;
    cyc++;
    reset = 1'b0;
    for (int k = 0; k < READ_LAT + 4; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      compute_expect();
      nVectors++;
      if ({gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data} !==
          {eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData}) begin
        nMiscompares++;
        $display("[TB] FAIL reset_post cyc=%0d got gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h, expected gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h",
                 cyc, gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data,
                 eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData);
      end
      advance();
    end
  endtask

  task test_contention();
    int n0, n1, p0, p1;
    n0 = 0; n1 = 0; p0 = 0; p1 = 0;
    for (int k = 0; k < 8 + READ_LAT + 2; k++) begin
      if (k < 8) drive(1, 0, AW'(16'h0020 + n0), 0, 0, 1, 0, AW'(16'h0040 + n1), 0, 0);
      else       drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      compute_expect();
      nVectors++;
      if ({gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data} !==
          {eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData}) begin
        nMiscompares++;
        $display("[TB] FAIL contention cyc=%0d got gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h, expected gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h",
                 cyc, gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data,
                 eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData);
      end
      if (eRv0 || eRv1) begin
        nVectors++;
        if (rdata !== eRdata) begin
          nMiscompares++;
          $display("[TB] FAIL contention_rdata cyc=%0d got=%h expected=%h", cyc, rdata, eRdata);
        end
      end
      if (k < 8) begin
        nVectors++;
        if (gnt0 !== (k % 2 == 0) || gnt1 !== (k % 2 == 1)) begin
          nMiscompares++;
          $display("[TB] FAIL contention_alternate k=%0d got gnt=%b%b expected gnt0=%0d", k, gnt0, gnt1, (k % 2 == 0));
        end
      end
      if (rvalid0) p0++;
      if (rvalid1) p1++;
      if (gnt0) n0++;
      if (gnt1) n1++;
      advance();
    end
    nVectors++;
    if (p0 !== 4 || p1 !== 4) begin
      nMiscompares++;
      $display("[TB] FAIL contention_pulses got rvalid0=%0d rvalid1=%0d, expected 4 and 4", p0, p1);
    end
  endtask

  task test_single_read();
    for (int k = 0; k < READ_LAT + 4; k++) begin
      if (k == 0) drive(1, 0, 16'h0010, 0, 0, 0, 0, 0, 0, 0);
      else        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      compute_expect();
      nVectors++;
      if ({gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data} !==
          {eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData}) begin
        nMiscompares++;
        $display("[TB] FAIL single_read cyc=%0d got gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h, expected gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h",
                 cyc, gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data,
                 eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData);
      end
      if (k == 0) begin
        nVectors++;
        if (gnt0 !== 1'b1) begin
          nMiscompares++;
          $display("[TB] FAIL single_gnt got=%b expected=1", gnt0);
        end
      end
      if (k == 1) begin
        nVectors++;
        if (ram_address !== 16'h0010) begin
          nMiscompares++;
          $display("[TB] FAIL single_addr got=%h expected=0010", ram_address);
        end
      end
      nVectors++;
      if (rvalid0 !== (k == 1 + READ_LAT) || rvalid1 !== 1'b0) begin
        nMiscompares++;
        $display("[TB] FAIL single_rvalid k=%0d got rv=%b%b expected rvalid0=%0d rvalid1=0", k, rvalid0, rvalid1, (k == 1 + READ_LAT));
      end
      if (k == 1 + READ_LAT) begin
        nVectors++;
        if (rdata !== 16'hBEEF) begin
          nMiscompares++;
          $display("[TB] FAIL single_rdata got=%h expected=beef", rdata);
        end
      end
      advance();
    end
  endtask

  task test_write_then_read();
    for (int k = 0; k < 8; k++) begin
      if (k == 0)      drive(0, 0, 0, 0, 0, 1, 1, 16'h0200, 16'h1234, 0);
      else if (k == 2) drive(0, 0, 0, 0, 0, 1, 0, 16'h0200, 0, 0);
      else             drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      compute_expect();
      nVectors++;
      if ({gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data} !==
          {eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData}) begin
        nMiscompares++;
        $display("[TB] FAIL write_read cyc=%0d got gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h, expected gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h",
                 cyc, gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data,
                 eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData);
      end
      nVectors++;
      if (ram_wren !== (k == 1)) begin
        nMiscompares++;
        $display("[TB] FAIL write_pulse k=%0d got wren=%b expected=%0d", k, ram_wren, (k == 1));
      end
      if (k == 3 + READ_LAT) begin
        nVectors++;
        if (rvalid1 !== 1'b1 || rdata !== 16'h1234) begin
          nMiscompares++;
          $display("[TB] FAIL write_readback got rvalid1=%b rdata=%h expected rvalid1=1 rdata=1234", rvalid1, rdata);
        end
      end
      advance();
    end
  endtask

  task test_lock();
    for (int k = 0; k < 11; k++) begin
      if (k == 0)      drive(1, 1, 16'h0030, 16'h00AA, 1, 0, 0, 0, 0, 0);
      else if (k <= 5) drive(0, 0, 0, 0, 1, 1, 0, 16'h0031, 0, 0);
      else if (k == 6) drive(0, 0, 0, 0, 0, 1, 0, 16'h0031, 0, 0);
      else             drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      compute_expect();
      nVectors++;
      if ({gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data} !==
          {eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData}) begin
        nMiscompares++;
        $display("[TB] FAIL lock cyc=%0d got gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h, expected gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h",
                 cyc, gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data,
                 eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData);
      end
      if (eRv0 || eRv1) begin
        nVectors++;
        if (rdata !== eRdata) begin
          nMiscompares++;
          $display("[TB] FAIL lock_rdata cyc=%0d got=%h expected=%h", cyc, rdata, eRdata);
        end
      end
`ifdef RAM_PORT_ARBITER_LOCK_EN
      if (k >= 1 && k <= 6) begin
        nVectors++;
        if (gnt1 !== (k == 6)) begin
          nMiscompares++;
          $display("[TB] FAIL lock_hold k=%0d got gnt1=%b expected=%0d", k, gnt1, (k == 6));
        end
      end
`else
      if (k == 1) begin
        nVectors++;
        if (gnt1 !== 1'b1) begin
          nMiscompares++;
          $display("[TB] FAIL lock_ignored got gnt1=%b expected=1", gnt1);
        end
      end
`endif
      advance();
    end
  endtask

  task test_random();
    for (int k = 0; k < 300 + READ_LAT + 3; k++) begin
      if (k < 300)
        drive(($urandom % 4) != 0, $urandom % 2, AW'($urandom_range(0, 63)), DW'($urandom), ($urandom % 4) == 0,
              ($urandom % 4) != 0, $urandom % 2, AW'($urandom_range(0, 63)), DW'($urandom), ($urandom % 4) == 0);
      else
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #4;
      compute_expect();
      nVectors++;
      if ({gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data} !==
          {eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData}) begin
        nMiscompares++;
        $display("[TB] FAIL random cyc=%0d got gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h, expected gnt=%b%b rv=%b%b busy=%b wren=%b addr=%h data=%h",
                 cyc, gnt0, gnt1, rvalid0, rvalid1, busy, ram_wren, ram_address, ram_data,
                 eGnt0, eGnt1, eRv0, eRv1, eBusy, expWren, expAddr, expData);
      end
      if (eRv0 || eRv1) begin
        nVectors++;
        if (rdata !== eRdata) begin
          nMiscompares++;
          $display("[TB] FAIL random_rdata cyc=%0d got=%h expected=%h", cyc, rdata, eRdata);
        end
      end
      advance();
    end
  endtask

  initial begin
    nVectors     = 0;
    nMiscompares = 0;
    cyc          = 0;
    mWinner      = -1;
    ramInit      = 1'b1;
    reset        = 1'b1;
    for (int i = 0; i < 1024; i++) shadow[i] = initVal(i);
    model_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("[TB] starting ram_port_arbiter bench");
    test_reset();
    test_contention();
    test_single_read();
    test_write_then_read();
    test_lock();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

  // Safety net so the run always ends on its own.
  initial begin
    #200000;
    $display("[TB] FAIL timeout simulation exceeded time limit, got no finish, expected finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
